crc8_framer: RTL and testbench

CRC8_FRAMER -- requirements
Module: crc8_framer

---
 rtl/crc8_framer.sv | 125 ++++++++++++
 tb/tb_crc8_framer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc8_framer.sv
// Byte-stream framer: forwards payload bytes unchanged and appends a CRC-8
// byte after each last-flagged payload byte, with valid/ready on both sides.
module crc8_framer #(
    parameter logic [7:0] POLYNOMIAL = 8'h07
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] s_data_i,
    input  logic       s_valid_i,
    input  logic       s_last_i,
    output logic       s_ready_o,
    output logic [7:0] m_data_o,
    output logic       m_valid_o,
    output logic       m_last_o,
    input  logic       m_ready_i,
    output logic [7:0] crc_o,
    output logic       crc_valid_o
);

    typedef enum logic {
        PAYLOAD = 1'b0,
        APPEND  = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] crc_q, crc_d;
    logic [7:0] m_data_q, m_data_d;
    logic       m_valid_q, m_valid_d;
    logic       m_last_q, m_last_d;
    logic [7:0] crc_out_q, crc_out_d;
    logic       crc_vld_q, crc_vld_d;

    logic out_free;
    logic s_acc;

    // MSB-first, non-reflected fold of a whole byte into the running CRC.
    function automatic logic [7:0] crc_fold(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ POLYNOMIAL) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    assign out_free = !m_valid_q || m_ready_i;
    assign s_acc    = s_valid_i && s_ready_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= PAYLOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PAYLOAD: if (s_acc && s_last_i) state_d = APPEND;
            APPEND:  if (out_free)          state_d = PAYLOAD;
            default:                        state_d = PAYLOAD;
        endcase
    end

    // s_ready_o is held low while reset is asserted so nothing is accepted then.
    always_comb begin
        s_ready_o = rst_ni && (state_q == PAYLOAD) && out_free;
        crc_d     = crc_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        crc_out_d = crc_out_q;
        crc_vld_d = 1'b0;
        if (out_free) begin
            m_valid_d = 1'b0;
        end
        case (state_q)
            PAYLOAD: begin
                if (s_acc) begin
                    m_data_d  = s_data_i;
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b0;
                    crc_d     = crc_fold(crc_q, s_data_i);
                end
            end
            APPEND: begin
                if (out_free) begin
                    m_data_d  = crc_q;
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b1;
                    crc_out_d = crc_q;
                    crc_vld_d = 1'b1;
                    crc_d     = 8'h00;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            crc_q     <= 8'h00;
            m_data_q  <= 8'h00;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            crc_out_q <= 8'h00;
            crc_vld_q <= 1'b0;
        end else begin
            crc_q     <= crc_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            crc_out_q <= crc_out_d;
            crc_vld_q <= crc_vld_d;
        end
    end

    assign m_data_o    = m_data_q;
    assign m_valid_o   = m_valid_q;
    assign m_last_o    = m_last_q;
    assign crc_o       = crc_out_q;
    assign crc_valid_o = crc_vld_q;

endmodule

// File: tb/tb_crc8_framer.sv
// Randomized bench for crc8_framer: a negedge monitor compares every output
// transfer and CRC pulse against a long-division CRC-8 reference model.
module tb_crc8_framer;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [7:0] s_data_i = 8'h00;
    logic       s_valid_i = 1'b0;
    logic       s_last_i = 1'b0;
    logic       s_ready_o;
    logic [7:0] m_data_o;
    logic       m_valid_o;
    logic       m_last_o;
    logic       m_ready_i = 1'b1;
    logic [7:0] crc_o;
    logic       crc_valid_o;

    crc8_framer #(.POLYNOMIAL(8'h07)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .s_data_i   (s_data_i),
        .s_valid_i  (s_valid_i),
        .s_last_i   (s_last_i),
        .s_ready_o  (s_ready_o),
        .m_data_o   (m_data_o),
        .m_valid_o  (m_valid_o),
        .m_last_o   (m_last_o),
        .m_ready_i  (m_ready_i),
        .crc_o      (crc_o),
        .crc_valid_o(crc_valid_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference CRC: remainder of (message * x^8) divided by x^8 + POLYNOMIAL.
    function automatic logic [7:0] crc_ref(input logic [7:0] msg[$]);
        logic [8:0] r;
        logic [8:0] g;
        r = 9'h000;
        g = {1'b1, 8'h07};
        for (int i = 0; i < msg.size() + 1; i++) begin
            for (int b = 7; b >= 0; b--) begin
                r = {r[7:0], (i < msg.size()) ? msg[i][b] : 1'b0};
                if (r[8]) r = r ^ g;
            end
        end
        return r[7:0];
    endfunction

    logic [8:0] exp_q[$];
    logic [7:0] crc_exp_q[$];
    logic [7:0] frame_q[$];
    logic       pending = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;
    logic       rand_rdy = 1'b0;
    logic       count_win = 1'b0;
    int         n_out = 0, n_last = 0, n_pulse = 0, n_bubble = 0;

    always @(negedge clk_i) begin : mon
        logic       free;
        logic [8:0] e;
        logic [7:0] c;
        if (!rst_ni) begin
            chk("rst_s_ready", 32'(s_ready_o), 0);
            exp_q.delete();
            crc_exp_q.delete();
            frame_q.delete();
            pending    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            free = !m_valid_o || m_ready_i;
            if (prev_stall) begin
                chk("stall_data", 32'(m_data_o), 32'(prev_data));
                chk("stall_last", 32'(m_last_o), 32'(prev_last));
            end
            chk("s_ready", 32'(s_ready_o), 32'(!pending && free));
            if (m_valid_o && m_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 32'(m_data_o), 32'(e[7:0]));
                    chk("out_last", 32'(m_last_o), 32'(e[8]));
                end
                n_out++;
                if (m_last_o) n_last++;
            end
            if (crc_valid_o) begin
                n_pulse++;
                if (crc_exp_q.size() == 0) chk("spurious_crc", 1, 0);
                else chk("crc_o", 32'(crc_o), 32'(crc_exp_q.pop_front()));
            end
            if (pending && free) begin
                pending = 1'b0;
            end else if (s_valid_i && s_ready_o) begin
                frame_q.push_back(s_data_i);
                exp_q.push_back({1'b0, s_data_i});
                if (s_last_i) begin
                    c = crc_ref(frame_q);
                    exp_q.push_back({1'b1, c});
                    crc_exp_q.push_back(c);
                    frame_q.delete();
                    pending = 1'b1;
                end
            end
            if (count_win && !s_ready_o) n_bubble++;
            prev_stall = m_valid_o && !m_ready_i;
            prev_data  = m_data_o;
            prev_last  = m_last_o;
        end
    end

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            m_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic l, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk_i);
            #1;
        end
        s_data_i  = d;
        s_last_i  = l;
        s_valid_i = 1'b1;
        n = 0;
        @(negedge clk_i);
        while (!s_ready_o) begin
            n++;
            if (n > 200) begin
                chk("send_timeout", 1, 0);
                break;
            end
            @(negedge clk_i);
        end
        @(posedge clk_i);
        #1;
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
    endtask

    task automatic send_str(input string s, input int max_gap);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], i == s.len() - 1, $urandom_range(0, max_gap));
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while ((exp_q.size() != 0 || pending || m_valid_o) && n < 500);
        if (n >= 500) chk("idle_timeout", 1, 0);
        @(posedge clk_i);
        #1;
    endtask

    int b_out, b_last, b_pulse;

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_m_valid", 32'(m_valid_o), 0);
        chk("rst_m_last", 32'(m_last_o), 0);
        chk("rst_m_data", 32'(m_data_o), 0);
        chk("rst_crc_o", 32'(crc_o), 0);
        chk("rst_crc_valid", 32'(crc_valid_o), 0);
        chk("rst_release_ready", 32'(s_ready_o), 1);
        @(posedge clk_i);
        #1;

        // Check string with downstream always ready.
        b_out = n_out; b_last = n_last; b_pulse = n_pulse;
        send_str("123456789", 0);
        wait_idle();
        chk("chk_bytes", 32'(n_out - b_out), 10);
        chk("chk_lasts", 32'(n_last - b_last), 1);
        chk("chk_pulses", 32'(n_pulse - b_pulse), 1);
        chk("chk_crc_f4", 32'(crc_o), 32'h0000_00F4);
        repeat (5) @(posedge clk_i);
        #1;
        chk("crc_retained", 32'(crc_o), 32'h0000_00F4);

        // Single-byte frames; the second proves per-frame reinitialisation.
        b_out = n_out;
        send_byte(8'h01, 1'b1, 0);
        wait_idle();
        chk("single01_crc", 32'(crc_o), 32'h0000_0007);
        send_byte(8'h00, 1'b1, 0);
        wait_idle();
        chk("single00_crc", 32'(crc_o), 0);
        chk("single_bytes", 32'(n_out - b_out), 4);

        // Check string under random backpressure.
        rand_rdy = 1'b1;
        b_out = n_out; b_last = n_last;
        send_str("123456789", 0);
        wait_idle();
        rand_rdy = 1'b0;
        chk("bp_bytes", 32'(n_out - b_out), 10);
        chk("bp_lasts", 32'(n_last - b_last), 1);
        chk("bp_crc_f4", 32'(crc_o), 32'h0000_00F4);

        // Reset after the fourth payload byte discards the frame.
        b_last = n_last;
        for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i), 1'b0, 0);
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("midrst_m_valid", 32'(m_valid_o), 0);
        @(posedge clk_i);
        #1;
        chk("midrst_no_crc", 32'(n_last - b_last), 0);
        send_str("123456789", 0);
        wait_idle();
        chk("postrst_crc_f4", 32'(crc_o), 32'h0000_00F4);

        // Back-to-back single-byte frames: one bubble per frame.
        repeat (2) @(posedge clk_i);
        #1;
        count_win = 1'b1;
        b_out = n_out; b_last = n_last;
        send_byte(8'h01, 1'b1, 0);
        send_byte(8'h01, 1'b1, 0);
        wait_idle();
        repeat (2) @(posedge clk_i);
        #1;
        count_win = 1'b0;
        chk("b2b_bubbles", 32'(n_bubble), 2);
        chk("b2b_bytes", 32'(n_out - b_out), 4);
        chk("b2b_lasts", 32'(n_last - b_last), 2);

        // Random frames, random gaps, random backpressure.
        rand_rdy = 1'b1;
        for (int f = 0; f < 20; f++) begin
            int len;
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                send_byte(8'($urandom), i == len - 1, $urandom_range(0, 2));
            end
        end
        wait_idle();
        rand_rdy = 1'b0;
        chk("rand_drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
